// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux block.
//   MODE_FIXED / MODE_RR : values of the arbitration mode input
//   DEFAULT_WIDTH        : default data width per channel
//   DEFAULT_N            : default number of input channels
package arb_mux_pkg;

  localparam logic MODE_FIXED    = 1'b0;
  localparam logic MODE_RR       = 1'b1;
  localparam int   DEFAULT_WIDTH = 32;
  localparam int   DEFAULT_N     = 4;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational grant logic for arb_mux.
//   req   [N]    : request per channel
//   ptr   [SELW] : round-robin start index (ignored in fixed mode)
//   mode  [1]    : MODE_FIXED = lowest index wins, MODE_RR = search from ptr
//   grant [N]    : one-hot grant, all zero when no request is set
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    grant
);

  logic            found;
  int              idx;
  logic [SELW-1:0] pos;

  // Walk the channels in search order; the first requester found wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (mode == MODE_RR) ? ((int'(ptr) + k) % N) : k;
      pos = SELW'(idx);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating multiplexer with a single registered output stage.
//   clk, rst             : clock, synchronous active-high reset
//   mode                 : MODE_FIXED or MODE_RR
//   in_data  [N*WIDTH]   : channel i at bits [i*WIDTH +: WIDTH]
//   in_valid [N]         : channel i offers a beat
//   in_ready [N]         : channel i beat accepted this cycle (one-hot or zero)
//   out_data [WIDTH]     : registered selected data
//   out_valid            : out_data holds a beat
//   out_ready            : consumer accepts the beat this cycle
//   out_sel  [SELW]      : channel that supplied out_data
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     grant;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  sel_idx;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .mode  (mode),
    .grant (grant)
  );

  // The output register can take a new beat when empty or being drained.
  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;
  // grant only ever selects a requesting channel, so any ready bit is a transfer.
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_idx  = SELW'(i);
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (xfer) begin
        out_data_d  = sel_data;
        out_sel_d   = sel_idx;
        out_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          ptr_d = (int'(sel_idx) == N - 1) ? '0 : sel_idx + SELW'(1);
        end
      end else begin
        // Nothing offered: empty the stage but keep the last data/sel visible.
        out_valid_d = 1'b0;
      end
    end
  end

  // Output stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_sel;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the output register must hold, and the RR pointer.
  bit          m_init = 1'b0;
  logic        m_vld  = 1'b0;
  logic [31:0] m_data = '0;
  int          m_sel  = 0;
  int          m_ptr  = 0;

  arb_mux #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Which channel must be accepted right now, from the arbitration rules.
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int c;
    r = '0;
    if (rst) return r;
    if (m_vld && !out_ready) return r;
    for (int k = 0; k < N; k++) begin
      c = mode ? (m_ptr + k) % N : k;
      if (in_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] g;
    g = exp_ready();
    if (rst) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_sel  = 0;
      m_ptr  = 0;
      m_init = 1'b1;
    end else if (!m_vld || out_ready) begin
      if (g != '0) begin
        for (int c = 0; c < N; c++) begin
          if (g[c]) begin
            m_data = in_data[c*WIDTH +: WIDTH];
            m_sel  = c;
          end
        end
        m_vld = 1'b1;
        if (mode) m_ptr = (m_sel + 1) % N;
      end else begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("mdl_in_ready",  64'(in_ready),  64'(exp_ready()));
      check("mdl_out_valid", 64'(out_valid), 64'(m_vld));
      check("mdl_out_data",  64'(out_data),  64'(m_data));
      check("mdl_out_sel",   64'(out_sel),   64'(m_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] d);
    in_data[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [31:0] d, input int s);
    check({nm, "_valid"}, 64'(out_valid), 64'(v));
    check({nm, "_data"},  64'(out_data),  64'(d));
    check({nm, "_sel"},   64'(out_sel),   64'(s));
  endtask

  int rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b1; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 32'h1000 * (i + 1));
    #1;
    check("rst_ready_pre", 64'(in_ready), 64'h0);

    // Reset held two cycles with every channel valid
    step();
    chk_out("rst1", 1'b0, 32'h0, 0);
    check("rst1_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("rst2", 1'b0, 32'h0, 0);
    check("rst2_ready", 64'(in_ready), 64'h0);

    // Fixed priority: ch1 always beats ch3
    rst = 1'b0; in_valid = 4'b1010; set_ch(1, 32'h11); set_ch(3, 32'h33);
    #1;
    check("fp_ready0", 64'(in_ready), 64'b0010);
    repeat (3) begin
      step();
      chk_out("fp", 1'b1, 32'h11, 1);
      check("fp_ready", 64'(in_ready), 64'b0010);
    end

    // Round robin over all four channels, one beat per cycle
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 32'h100 + i);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out("rr", 1'b1, 32'h100 + rr_seq[k], rr_seq[k]);
    end

    // Sparse RR, then a fixed-mode cycle that must not move the pointer
    in_valid = 4'b1010;
    step(); check("rr_sparse1", 64'(out_sel), 64'd1);
    step(); check("rr_sparse3", 64'(out_sel), 64'd3);
    mode = 1'b0;
    step(); check("mode_fixed_sel", 64'(out_sel), 64'd1);
    mode = 1'b1; in_valid = 4'b1001;
    step(); check("mode_rr_ptr_kept", 64'(out_sel), 64'd0);

    // Backpressure holds the output and blocks every input
    mode = 1'b0; in_valid = 4'b0001; set_ch(0, 32'hA5A5A5A5);
    step();
    chk_out("bp_load", 1'b1, 32'hA5A5A5A5, 0);
    out_ready = 1'b0; in_valid = 4'b0100; set_ch(2, 32'h2222);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 64'(in_ready), 64'h0);
      chk_out("bp_hold", 1'b1, 32'hA5A5A5A5, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'b0100);
    step();
    chk_out("bp_after", 1'b1, 32'h2222, 2);

    // Drain: single beat then idle
    in_valid = 4'b0001; set_ch(0, 32'hC0);
    step();
    chk_out("drain_beat", 1'b1, 32'hC0, 0);
    in_valid = 4'b0000;
    step();
    chk_out("drain_idle1", 1'b0, 32'hC0, 0);
    step();
    chk_out("drain_idle2", 1'b0, 32'hC0, 0);

    // Reset mid-operation after a grant to ch2 (pointer now 3)
    mode = 1'b1; in_valid = 4'b0100;
    step();
    chk_out("mid_grant2", 1'b1, 32'h2222, 2);
    rst = 1'b1; in_valid = 4'b1111;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("mid_rst", 1'b0, 32'h0, 0);
    rst = 1'b0;
    #1;
    check("mid_resume_ready", 64'(in_ready), 64'b0001);
    step();
    chk_out("mid_resume", 1'b1, 32'hC0, 0);

    // Mixed traffic checked against the reference on every cycle
    for (int k = 0; k < 60; k++) begin
      mode      = 1'($urandom_range(0, 1));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < N; i++) set_ch(i, $urandom);
      step();
    end
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel (1..64).
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16, power of two not required).
REQ-003 SHALL have parameter SELW, default $clog2(N), width of out_sel.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  channel i offers data.
REQ-009 in_ready  output  N  channel i data accepted this cycle when in_valid[i] also high.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds a beat.
REQ-012 out_ready  input  1  consumer accepts beat this cycle.
REQ-013 out_sel  output  SELW  index of channel that supplied current out_data.

Function
REQ-014 SHALL define load = !out_valid | out_ready; arbitration occurs only in cycles with load high.
REQ-015 SHALL assert at most one in_ready bit per cycle: in_ready[i] = load & grant[i]; in_ready combinational from in_valid, mode, pointer, out_valid, out_ready.
REQ-016 SHALL, mode 0, grant lowest-index i with in_valid[i] high.
REQ-017 SHALL, mode 1, grant first i with in_valid[i] high searching ptr, ptr+1, ... modulo N.
REQ-018 SHALL, on transfer from channel g in mode 1, set ptr to (g+1) mod N at next edge (wrap N-1 -> 0); ptr unchanged in mode 0 and in cycles without transfer.
REQ-019 SHALL, on transfer, register out_data = channel g data, out_sel = g, out_valid = 1 at next edge: latency exactly 1 cycle.
REQ-020 SHALL, when load high and no in_valid bit set, clear out_valid at next edge; out_data/out_sel hold last values.
REQ-021 SHALL hold out_data, out_sel, out_valid stable while out_valid & !out_ready (backpressure); no in_ready asserted then.
REQ-022 SHALL sustain one beat per cycle when out_ready held high and any input valid (simultaneous accept-out and load-in same cycle).
REQ-023 SHALL apply a change of mode in the same cycle's arbitration; ptr retains its value across mode changes.
REQ-024 SHALL never drop or duplicate a beat: each in_valid&in_ready cycle yields exactly one out_valid&out_ready cycle, in order.
REQ-025 SHALL, mode 1 with all N inputs continuously valid, grant each channel exactly once per N consecutive transfers.

Reset
REQ-026 SHALL, with rst high at an edge, set out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, overriding any transfer in that cycle.
REQ-027 SHALL drive in_ready = 0 while rst high; a beat held at reset assertion is discarded.
REQ-028 SHALL resume arbitration the first cycle after rst deasserts, starting from ptr = 0.

Structure
REQ-029 SHALL place mode constants (MODE_FIXED = 0, MODE_RR = 1) and default WIDTH/N in shared package arb_mux_pkg.
REQ-030 SHALL implement grant logic in one sub-module rr_arbiter (inputs req[N], ptr, mode; output one-hot grant[N]); arb_mux holds ptr and the output register.

Verification
REQ-031 Reset: rst high 2 cycles with in_valid = 4'b1111 -> in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0.
REQ-032 Fixed priority: mode 0, in_valid = 4'b1010, data ch1 = 32'h11, ch3 = 32'h33, out_ready = 1 -> in_ready = 4'b0010, next cycle out_data = 32'h11, out_sel = 1; repeated every cycle, ch3 starved.
REQ-033 Round robin wrap: mode 1, in_valid = 4'b1111, out_ready = 1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one beat per cycle.
REQ-034 Backpressure: out_valid = 1 with out_data = 32'hA5A5A5A5, out_ready = 0 for 3 cycles, in_valid = 4'b0100 -> out_data stable, in_ready = 0; out_ready = 1 -> in_ready = 4'b0100 same cycle, ch2 data out next cycle.
REQ-035 Drain: single beat on ch0, then in_valid = 0, out_ready = 1 -> out_valid 1 for one cycle then 0; out_sel stays 0.
REQ-036 Reset mid-operation: mode 1 after grant to ch2 (ptr = 3), out_valid = 1, assert rst 1 cycle -> out_valid = 0, next arbitration with in_valid = 4'b1111 grants ch0.
